// File: rtl/int_divider_seq.sv
`default_nettype none
// ============================================================================
// Module   : int_divider_seq
// Purpose  : Iterative radix-2 restoring integer divider (RV32M DIV/DIVU/
//            REM/REMU). Quotient and remainder are produced together,
//            one quotient bit per clock, then sign-corrected in a final
//            cycle. Responder side of the start/ok/err divider handshake.
// Ports    : clock, reset     - clock, synchronous active-high reset
//            start            - request pulse, honoured only while ok=1
//            signed_op        - 1: DIV/REM, 0: DIVU/REMU
//            A, B             - dividend / divisor, sampled with start
//            D, R             - quotient / remainder, held until next completion
//            ok               - 1 = idle and results valid
//            err              - 1 = last completed operation had B==0
// Options  : IDIV_EARLY_OUT_EN - when defined, divide-by-zero, signed
//            overflow and |A|<|B| complete in the accepting cycle.
// Revision : 1.0 - initial release
// ============================================================================
module int_divider_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] R,
  output logic             ok,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef IDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  // Magnitude of an operand: two's-complement negate only for signed ops
  // with the sign bit set. The most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  function automatic logic is_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic s);
    return s && (a == MIN_NEG) && (b == {WIDTH{1'b1}});
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] a_q,     a_d;     // original dividend (div-by-zero R, signs)
  logic [WIDTH-1:0] b_q,     b_d;     // original divisor (zero test, signs)
  logic             sgn_q,   sgn_d;
  logic [WIDTH-1:0] dvd_q,   dvd_d;   // |A| shifts out the top, quotient shifts in
  logic [WIDTH-1:0] dvs_q,   dvs_d;   // |B|
  logic [WIDTH-1:0] rem_q,   rem_d;   // partial remainder, always < |B|
  logic [WIDTH-1:0] d_q,     d_d;
  logic [WIDTH-1:0] r_q,     r_d;
  logic             err_q,   err_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   shift_rem, trial;
  logic             neg_q, neg_r;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    d_d     = d_q;
    r_d     = r_q;
    err_d   = err_q;

    mag_a     = mag(A, signed_op);
    mag_b     = mag(B, signed_op);
    // One extra bit: the shifted remainder can reach 2*|B|-1.
    shift_rem = {rem_q, dvd_q[WIDTH-1]};
    trial     = shift_rem - {1'b0, dvs_q};
    neg_q     = sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    neg_r     = sgn_q && a_q[WIDTH-1];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          sgn_d   = signed_op;
          dvd_d   = mag_a;
          dvs_d   = mag_b;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_CALC;
          if (EARLY_OUT) begin
            if (B == '0) begin
              d_d     = '1;
              r_d     = A;
              err_d   = 1'b1;
              state_d = S_IDLE;
            end else if (is_ovf(A, B, signed_op)) begin
              d_d     = A;
              r_d     = '0;
              err_d   = 1'b0;
              state_d = S_IDLE;
            end else if (mag_a < mag_b) begin
              // Remainder is the whole dividend, sign included.
              d_d     = '0;
              r_d     = A;
              err_d   = 1'b0;
              state_d = S_IDLE;
            end
          end
        end
      end

      S_CALC: begin
        // Borrow out of the trial subtract means the quotient bit is 0
        // and the shifted remainder is kept (the "restore").
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shift_rem[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        if (b_q == '0) begin
          d_d   = '1;
          r_d   = a_q;
          err_d = 1'b1;
        end else if (is_ovf(a_q, b_q, sgn_q)) begin
          // The datapath already yields this; forced for robustness.
          d_d   = a_q;
          r_d   = '0;
          err_d = 1'b0;
        end else begin
          d_d   = neg_q ? (~dvd_q + 1'b1) : dvd_q;
          r_d   = neg_r ? (~rem_q + 1'b1) : rem_q;
          err_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      d_q     <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      d_q     <= d_d;
      r_q     <= r_d;
      err_q   <= err_d;
    end
  end

  assign D   = d_q;
  assign R   = r_q;
  assign err = err_q;
  assign ok  = (state_q == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_int_divider_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_divider_seq
// Purpose  : Self-checking bench for int_divider_seq (WIDTH=32). Expected
//            results come from a behavioural divide model and are queued
//            when a request is driven, then popped when ok returns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_divider_seq;

  localparam int WIDTH    = 32;
  localparam int FULL_LAT = WIDTH + 1;
  localparam int MAX_WAIT = 200;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] A, B;
  logic [WIDTH-1:0] D, R;
  logic             ok, err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] r;
    logic             e;
    int               low;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] last_d;

  int_divider_seq #(.WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .signed_op (signed_op),
    .A         (A),
    .B         (B),
    .D         (D),
    .R         (R),
    .ok        (ok),
    .err       (err)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference divide with RISC-V semantics (SV / and % truncate toward zero).
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic s);
    exp_t             x;
    logic [WIDTH-1:0] ma, mb;
    logic             early;
    x.e = 1'b0;
    if (b == 0) begin
      x.d = '1; x.r = a; x.e = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      x.d = a; x.r = '0;
    end else if (s) begin
      x.d = $signed(a) / $signed(b);
      x.r = $signed(a) % $signed(b);
    end else begin
      x.d = a / b;
      x.r = a % b;
    end
    ma = (s && a[WIDTH-1]) ? -a : a;
    mb = (s && b[WIDTH-1]) ? -b : b;
    early = (b == 0) || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || (ma < mb);
`ifdef IDIV_EARLY_OUT_EN
    x.low = early ? 0 : FULL_LAT;
`else
    x.low = FULL_LAT;
    if (early) x.low = FULL_LAT;
`endif
    return x;
  endfunction

  // Drives one request; inj>0 re-asserts start (junk operands) on the cycle
  // whose sampling edge is number inj, which must be ignored.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic s, input int inj);
    exp_t x;
    int   lat;
    @(negedge clock);
    A = a; B = b; signed_op = s; start = 1'b1;
    sb.push_back(model(a, b, s));
    @(negedge clock);
    start = 1'b0;
    lat = 0;
    while (!ok && lat < MAX_WAIT) begin
      lat++;
      if (lat == 16) check("hold_d", D, last_d);
      if (lat == inj) begin
        start = 1'b1; A = 32'd9; B = 32'd3; signed_op = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    start = 1'b0;
    if (!ok) begin
      check("timeout_ok", {31'b0, ok}, 32'd1);
    end else if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      check("latency", lat, x.low);
      check("D", D, x.d);
      check("R", R, x.r);
      check("err", {31'b0, err}, {31'b0, x.e});
      last_d = x.d;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; signed_op = 1'b0; A = '0; B = '0;
    last_d = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("rst_D", D, 32'd0);
    check("rst_R", R, 32'd0);
    check("rst_ok", {31'b0, ok}, 32'd1);
    check("rst_err", {31'b0, err}, 32'd0);

    run_op(32'd100, 32'd7, 1'b0, 0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    run_op(32'd5, 32'd0, 1'b0, 0);
    repeat (3) @(negedge clock);
    check("err_sticky", {31'b0, err}, 32'd1);
    run_op(32'd5, 32'd0, 1'b1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    run_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    run_op(32'd3, 32'd10, 1'b0, 0);
    run_op(32'hFFFF_FFFD, 32'd10, 1'b1, 0);

    // start while busy, then start on the completion edge
    run_op(32'd100, 32'd7, 1'b0, 10);
    repeat (2) begin
      @(negedge clock);
      check("ok_stay_busy", {31'b0, ok}, 32'd1);
    end
    run_op(32'd1000, 32'd33, 1'b0, FULL_LAT);
    repeat (2) begin
      @(negedge clock);
      check("ok_stay_fix", {31'b0, ok}, 32'd1);
    end

    // reset mid-operation
    @(negedge clock);
    A = 32'd100; B = 32'd7; signed_op = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst_D", D, 32'd0);
    check("mid_rst_R", R, 32'd0);
    check("mid_rst_ok", {31'b0, ok}, 32'd1);
    check("mid_rst_err", {31'b0, err}, 32'd0);
    last_d = '0;
    run_op(32'd20, 32'd6, 1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_op(ra, rb, 1'($urandom_range(0, 1)), 0);
    end

    if (sb.size() != 0) check("sb_leftover", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
